// File: rtl/serdes_8b10b_rx_byte_align.sv
// serdes_8b10b_rx_byte_align: rotates RX words so the comma K-character lands in lane 0,
// with a hunt/check/lock qualifier that has hysteresis on both lock and unlock.
module serdes_8b10b_rx_byte_align #(
  parameter int         LANES      = 8,
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         LOCK_CNT   = 4,
  parameter int         UNLOCK_CNT = 3,
  localparam int        OW         = $clog2(LANES)
) (
  input  logic               I_rx_clk,
  input  logic               I_rst_n,
  input  logic [LANES*8-1:0] I_rx_data,
  input  logic [LANES-1:0]   I_rx_k_ctrl,
  input  logic               I_realign,
  output logic [LANES*8-1:0] O_rx_data,
  output logic [LANES-1:0]   O_rx_k_ctrl,
  output logic               O_rx_valid,
  output logic               O_lock,
  output logic [OW-1:0]      O_offset
);
  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;
  localparam logic [3:0] LC = 4'(LOCK_CNT);
  localparam logic [3:0] UC = 4'(UNLOCK_CNT);
  logic [LANES*8-1:0] d1, d2, sh_d;
  logic [LANES-1:0] k1, k2, sh_k;
  logic [LANES*16-1:0] dcat;
  logic [LANES*2-1:0] kcat;
  state_t state, state_nx;
  logic [OW-1:0] cand, cand_nx, sel, sel_nx, off;
  logic [3:0] cnt, cnt_nx, miss, miss_nx;
  logic comma;
  always_comb begin
    comma = 1'b0;
    off = '0;
    for (int i = 0; i < LANES; i++)
      if ($onehot(k1) && k1[i] && d1[8*i +: 8] == COMMA) begin
        comma = 1'b1;
        off = OW'(i);
      end
  end
  // d2 is the older word, so the byte window starting at sel straddles into d1
  assign dcat = {d1, d2};
  assign kcat = {k1, k2};
  always_comb begin
    sh_d = '0;
    sh_k = '0;
    for (int i = 0; i < LANES; i++) begin
      sh_d[8*i +: 8] = dcat[8*(i + int'(sel)) +: 8];
      sh_k[i] = kcat[i + int'(sel)];
    end
  end
  always_comb begin
    state_nx = state;
    cand_nx = cand;
    cnt_nx = cnt;
    miss_nx = miss;
    sel_nx = sel;
    if (I_realign) begin
      state_nx = HUNT;
      cnt_nx = '0;
      miss_nx = '0;
    end else if (comma && state == LOCK) begin
      miss_nx = (off == sel) ? '0 : miss + 4'd1;
      if (off != sel && miss + 4'd1 == UC) begin
        state_nx = HUNT;
        cnt_nx = '0;
        miss_nx = '0;
      end
    end else if (comma) begin
      cand_nx = off;
      cnt_nx = (state == CHECK && off == cand) ? cnt + 4'd1 : 4'd1;
      state_nx = (cnt_nx == LC) ? LOCK : CHECK;
      if (cnt_nx == LC) begin
        sel_nx = off;
        miss_nx = '0;
      end
    end
  end
  always_ff @(posedge I_rx_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      d1 <= '0;
      d2 <= '0;
      k1 <= '0;
      k2 <= '0;
      O_rx_data <= '0;
      O_rx_k_ctrl <= '0;
      O_rx_valid <= 1'b0;
      state <= HUNT;
      cand <= '0;
      cnt <= '0;
      miss <= '0;
      sel <= '0;
    end else begin
      d1 <= I_rx_data;
      d2 <= d1;
      k1 <= I_rx_k_ctrl;
      k2 <= k1;
      O_rx_data <= sh_d;
      O_rx_k_ctrl <= sh_k;
      O_rx_valid <= O_lock;
      state <= state_nx;
      cand <= cand_nx;
      cnt <= cnt_nx;
      miss <= miss_nx;
      sel <= sel_nx;
    end
  assign O_lock = state == LOCK;
  assign O_offset = sel;
endmodule

// File: tb/tb_serdes_8b10b_rx_byte_align.sv
// tb_serdes_8b10b_rx_byte_align: directed and random checks of the byte aligner against
// a byte-stream reference model; a second LANES=4 / LOCK_CNT=1 instance checks pass-through.
module tb_serdes_8b10b_rx_byte_align;
  localparam int L = 8;
  localparam int LOCK_CNT = 4;
  localparam int UNLOCK_CNT = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic realign = 1'b0;
  logic [63:0] rx_data = '0;
  logic [7:0] rx_k = '0;
  logic [63:0] o_data;
  logic [7:0] o_k;
  logic o_valid, o_lock;
  logic [2:0] o_off;
  logic [31:0] b_data = '0;
  logic [3:0] b_k = '0;
  logic [31:0] b_odata;
  logic [3:0] b_ok;
  logic b_valid, b_lock;
  logic [1:0] b_off;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serdes_8b10b_rx_byte_align #(.LANES(8)) dut (
    .I_rx_clk(clk), .I_rst_n(rst_n), .I_rx_data(rx_data), .I_rx_k_ctrl(rx_k),
    .I_realign(realign), .O_rx_data(o_data), .O_rx_k_ctrl(o_k),
    .O_rx_valid(o_valid), .O_lock(o_lock), .O_offset(o_off));

  serdes_8b10b_rx_byte_align #(.LANES(4), .LOCK_CNT(1)) dut4 (
    .I_rx_clk(clk), .I_rst_n(rst_n), .I_rx_data(b_data), .I_rx_k_ctrl(b_k),
    .I_realign(1'b0), .O_rx_data(b_odata), .O_rx_k_ctrl(b_ok),
    .O_rx_valid(b_valid), .O_lock(b_lock), .O_offset(b_off));

  // reference model: the input as one flat byte stream plus an alignment tracker
  logic [7:0] sb [0:4095];
  logic kb [0:4095];
  logic [31:0] w4 [0:511];
  logic [3:0] k4 [0:511];
  int wn;
  logic [63:0] pd;
  logic [7:0] pk;
  bit m_lock;
  int m_sel, m_cand, m_run, m_miss;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int comma_pos(input logic [63:0] d, input logic [7:0] k);
    if ($countones(k) != 1) return -1;
    for (int i = 0; i < L; i++)
      if (k[i]) return (d[8*i +: 8] == 8'hBC) ? i : -1;
    return -1;
  endfunction

  function automatic logic [8:0] sbyte(input int idx);
    return (idx < 0) ? 9'h0 : {kb[idx], sb[idx]};
  endfunction

  task automatic reset_model();
    wn = 0;
    pd = '0;
    pk = '0;
    m_lock = 0;
    m_sel = 0;
    m_cand = 0;
    m_run = 0;
    m_miss = 0;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] k, input bit ra);
    logic [63:0] ed;
    logic [7:0] ek;
    logic [8:0] b;
    logic [31:0] bd;
    logic [3:0] bk;
    bit ev;
    int c;
    bd = $urandom;
    bk = 4'h0;
    if (wn == 0) begin
      bd[7:0] = 8'hBC;
      bk = 4'h1;
    end
    rx_data = d;
    rx_k = k;
    realign = ra;
    b_data = bd;
    b_k = bk;
    for (int i = 0; i < L; i++) begin
      sb[wn*L+i] = d[8*i +: 8];
      kb[wn*L+i] = k[i];
    end
    w4[wn] = bd;
    k4[wn] = bk;
    // output after edge wn is the stream window two words back, offset by the current alignment
    for (int i = 0; i < L; i++) begin
      b = sbyte((wn - 2) * L + m_sel + i);
      ed[8*i +: 8] = b[7:0];
      ek[i] = b[8];
    end
    ev = m_lock;
    c = comma_pos(pd, pk);
    if (ra) begin
      m_lock = 0;
      m_run = 0;
      m_miss = 0;
    end else if (c >= 0 && !m_lock) begin
      m_run = (m_run > 0 && c == m_cand) ? m_run + 1 : 1;
      m_cand = c;
      if (m_run == LOCK_CNT) begin
        m_lock = 1;
        m_sel = c;
        m_miss = 0;
        m_run = 0;
      end
    end else if (c >= 0) begin
      if (c == m_sel) m_miss = 0;
      else begin
        m_miss = m_miss + 1;
        if (m_miss == UNLOCK_CNT) begin
          m_lock = 0;
          m_miss = 0;
        end
      end
    end
    pd = d;
    pk = k;
    @(posedge clk);
    #1;
    realign = 1'b0;
    check("data", o_data, ed);
    check("k", o_k, ek);
    check("valid", o_valid, ev);
    check("lock", o_lock, m_lock);
    check("offset", o_off, m_sel);
    if (ev && ek == 8'h01 && ed[7:0] == 8'hBC) begin
      check("lane0_byte", o_data[7:0], 8'hBC);
      check("lane0_k", o_k, 8'h01);
    end
    check("b_lock", b_lock, wn >= 1);
    check("b_valid", b_valid, wn >= 2);
    check("b_off", b_off, 0);
    check("b_data", b_odata, wn >= 2 ? w4[wn-2] : 32'h0);
    check("b_k", b_ok, wn >= 2 ? k4[wn-2] : 4'h0);
    wn++;
  endtask

  task automatic send_comma(input int p, input bit ra = 0);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[8*p +: 8] = 8'hBC;
    push(d, 8'h01 << p, ra);
  endtask

  task automatic send_fill(input bit ra = 0);
    push({$urandom, $urandom}, 8'h00, ra);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_k"}, o_k, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_lock"}, o_lock, 0);
    check({tag, "_off"}, o_off, 0);
    check({tag, "_b_data"}, b_odata, 0);
    check({tag, "_b_lock"}, b_lock, 0);
  endtask

  initial begin
    int r, ctr;
    logic [63:0] d;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // byte-counter payload with a comma at byte 3 every 4th word
    ctr = 0;
    for (int j = 0; j < 6; j++)
      for (int w = 0; w < 4; w++) begin
        for (int i = 0; i < 8; i++) begin
          d[8*i +: 8] = 8'(ctr);
          ctr++;
        end
        if (w == 3) d[31:24] = 8'hBC;
        push(d, w == 3 ? 8'h08 : 8'h00, 0);
      end
    check("p1_lock", o_lock, 1);
    check("p1_off", o_off, 3);
    // candidate moves from 5 to 2 while checking
    send_fill(1);
    send_comma(5);
    send_comma(5);
    repeat (4) send_comma(2);
    check("p2_not_yet", o_lock, 0);
    send_fill();
    check("p2_lock", o_lock, 1);
    check("p2_off", o_off, 2);
    // unlock hysteresis at offset 3
    send_fill(1);
    repeat (4) send_comma(3);
    send_fill();
    send_comma(6);
    send_comma(6);
    send_comma(3);
    send_comma(6);
    send_comma(6);
    send_fill();
    check("p3_held", o_lock, 1);
    send_comma(6);
    send_fill();
    check("p3_unlock", o_lock, 0);
    check("p3_valid_lag", o_valid, 1);
    send_fill();
    check("p3_valid_fall", o_valid, 0);
    check("p3_sel_kept", o_off, 3);
    // malformed K patterns do not disturb the count
    send_fill(1);
    send_comma(3);
    send_comma(3);
    d = {$urandom, $urandom};
    d[7:0] = 8'hBC;
    d[31:24] = 8'hBC;
    push(d, 8'h09, 0);
    d[7:0] = 8'hFB;
    push(d, 8'h01, 0);
    push(d, 8'h00, 0);
    send_comma(3);
    send_comma(3);
    send_fill();
    check("p4_lock", o_lock, 1);
    // realign coincident with a comma in d1: that comma is discarded
    send_comma(3);
    send_fill(1);
    check("p5_realign", o_lock, 0);
    repeat (3) send_comma(3);
    send_fill();
    check("p5_not_yet", o_lock, 0);
    send_comma(3);
    send_fill();
    check("p5_relock", o_lock, 1);
    // random traffic
    repeat (150) begin
      r = $urandom_range(0, 99);
      if (r < 30) send_comma(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 3);
      else if (r < 36) begin
        d = {$urandom, $urandom};
        d[7:0] = ($urandom_range(0, 1) == 0) ? 8'hFB : 8'hBC;
        d[31:24] = 8'hBC;
        push(d, ($urandom_range(0, 1) == 0) ? 8'h09 : 8'h01, 0);
      end else if (r < 39) send_fill(1);
      else send_fill();
    end
    // asynchronous reset while locked
    send_fill(1);
    repeat (4) send_comma(3);
    send_fill();
    send_fill();
    check("p6_locked", o_lock, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rx_data = '0;
    rx_k = '0;
    rst_n = 1'b1;
    reset_model();
    send_fill();
    send_fill();
    check("p6_no_stale", o_lock, 0);
    repeat (4) send_comma(3);
    send_fill();
    send_fill();
    check("p6_relock", o_valid, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
